// File: rtl/mem_wb_pipe_reg.sv
// MEM->WB pipeline register: DEPTH stages with stall/flush, write-back mux at capture,
// youngest-first forwarding lookup and a registered occupancy counter.
module mem_wb_pipe_reg #(
    parameter int DATA_W = 32,
    parameter int DEST_W = 4,
    parameter int DEPTH  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    input  logic              wb_en,
    input  logic              mem_read,
    input  logic [DEST_W-1:0] dest,
    input  logic [DATA_W-1:0] alu,
    input  logic [DATA_W-1:0] mem_data,
    input  logic [DEST_W-1:0] src1,
    input  logic [DEST_W-1:0] src2,
    output logic              wb_en_out,
    output logic              mem_read_out,
    output logic [DEST_W-1:0] dest_out,
    output logic [DATA_W-1:0] wb_value,
    output logic              fwd1_hit,
    output logic              fwd2_hit,
    output logic [DATA_W-1:0] fwd1_data,
    output logic [DATA_W-1:0] fwd2_data,
    output logic [2:0]        occupancy
);

    generate
        if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
            $error("mem_wb_pipe_reg: DEPTH must be in 1..4");
        end
    endgenerate

    logic [DEPTH-1:0]  stg_valid;
    logic [DEPTH-1:0]  stg_wb;
    logic [DEPTH-1:0]  stg_mr;
    logic [DEST_W-1:0] stg_dest  [DEPTH];
    logic [DATA_W-1:0] stg_value [DEPTH];
    logic [2:0]        occ_next;

    // Counter tracks valids entering stage 0 and leaving the last stage.
    always_comb begin
        occ_next = occupancy + {2'b00, in_valid} - {2'b00, stg_valid[DEPTH-1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stg_valid <= '0;
            stg_wb    <= '0;
            stg_mr    <= '0;
            occupancy <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                stg_dest[k]  <= '0;
                stg_value[k] <= '0;
            end
        end else if (flush) begin
            stg_valid <= '0;
            stg_wb    <= '0;
            stg_mr    <= '0;
            occupancy <= '0;
        end else if (!stall) begin
            // Bubbles still load dest/value but never carry control bits.
            stg_valid[0] <= in_valid;
            stg_wb[0]    <= in_valid & wb_en;
            stg_mr[0]    <= in_valid & mem_read;
            stg_dest[0]  <= dest;
            stg_value[0] <= mem_read ? mem_data : alu;
            for (int k = 1; k < DEPTH; k++) begin
                stg_valid[k] <= stg_valid[k-1];
                stg_wb[k]    <= stg_wb[k-1];
                stg_mr[k]    <= stg_mr[k-1];
                stg_dest[k]  <= stg_dest[k-1];
                stg_value[k] <= stg_value[k-1];
            end
            occupancy <= occ_next;
        end
    end

    assign wb_en_out    = stg_valid[DEPTH-1] & stg_wb[DEPTH-1];
    assign mem_read_out = stg_valid[DEPTH-1] & stg_mr[DEPTH-1];
    assign dest_out     = stg_dest[DEPTH-1];
    assign wb_value     = stg_value[DEPTH-1];

    // Scan oldest to youngest so a younger match overwrites an older one.
    always_comb begin
        fwd1_hit  = 1'b0;
        fwd2_hit  = 1'b0;
        fwd1_data = '0;
        fwd2_data = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (stg_valid[k] && stg_wb[k] && stg_dest[k] == src1) begin
                fwd1_hit  = 1'b1;
                fwd1_data = stg_value[k];
            end
            if (stg_valid[k] && stg_wb[k] && stg_dest[k] == src2) begin
                fwd2_hit  = 1'b1;
                fwd2_data = stg_value[k];
            end
        end
    end

    always @(posedge clk) begin
        if (!rst) begin
            assert (occupancy == 3'($countones(stg_valid)));
        end
    end

endmodule
